// File: rtl/trb_mem_ctrl_if.sv
// Tracer <-> trace buffer bus. The tracer (master) stores words, raises
// trigger events and requests loads; the memory controller (slave) grants.
interface trb_mem_ctrl_if #(
  parameter int TRB_WIDTH = 32,
  parameter int TRB_DEPTH = 64
);
  localparam int AW = $clog2(TRB_DEPTH);
  localparam int PW = $clog2(TRB_WIDTH);

  logic                 MODE_I;
  logic [AW-1:0]        TRG_DELAY_I;
  logic                 STORE_I;
  logic [TRB_WIDTH-1:0] DATA_I;
  logic                 STORE_PERM_O;
  logic                 TRG_EVENT_I;
  logic [PW-1:0]        EVENT_POS_I;
  logic                 TRG_DELAYED_O;
  logic                 LOAD_REQUEST_I;
  logic                 LOAD_GRANT_O;
  logic [TRB_WIDTH-1:0] DATA_O;
  logic [AW-1:0]        TRG_ADDR_O;
  logic [PW-1:0]        EVENT_POS_O;
  logic [AW:0]          FILL_O;

  modport master (
    output MODE_I, TRG_DELAY_I, STORE_I, DATA_I, TRG_EVENT_I, EVENT_POS_I,
           LOAD_REQUEST_I,
    input  STORE_PERM_O, TRG_DELAYED_O, LOAD_GRANT_O, DATA_O, TRG_ADDR_O,
           EVENT_POS_O, FILL_O
  );

  modport slave (
    input  MODE_I, TRG_DELAY_I, STORE_I, DATA_I, TRG_EVENT_I, EVENT_POS_I,
           LOAD_REQUEST_I,
    output STORE_PERM_O, TRG_DELAYED_O, LOAD_GRANT_O, DATA_O, TRG_ADDR_O,
           EVENT_POS_O, FILL_O
  );
endinterface

// File: rtl/trb_mem_ctrl.sv
// Trace buffer memory controller. Trace mode: ring buffer that keeps
// capturing until TRG_DELAY_I words after the trigger, then replays the
// buffer oldest-first forever. Stream mode: plain FIFO between tracer stores
// and loads. All outputs are registered.
module trb_mem_ctrl #(
  parameter int TRB_WIDTH = 32,
  parameter int TRB_DEPTH = 64
) (
  input logic            FPGA_CLK_I,
  input logic            RST_NI,
  trb_mem_ctrl_if.slave  bus
);
  localparam int AW = $clog2(TRB_DEPTH);
  localparam int PW = $clog2(TRB_WIDTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TRB_DEPTH);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_POST = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_READ = 2'd3;

  logic [TRB_WIDTH-1:0] r_mem [TRB_DEPTH];

  logic [1:0]           r_state;
  logic                 r_mode;
  logic                 r_mode_vld;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic [AW-1:0]        r_cnt;
  logic                 r_perm;
  logic                 r_grant;
  logic                 r_delayed;
  logic [TRB_WIDTH-1:0] r_data;
  logic [AW-1:0]        r_trg_addr;
  logic [PW-1:0]        r_evt_pos;

  logic                 w_mode;
  logic                 w_wr_acc;
  logic                 w_can_rd;
  logic                 w_rd_acc;
  logic                 w_trg_arm;
  logic                 w_enter_done;
  logic [1:0]           w_state_nxt;
  logic [AW-1:0]        w_cnt_nxt;
  logic [AW-1:0]        w_wr_ptr_nxt;
  logic [AW:0]          w_count_nxt;
  logic                 w_perm_nxt;

  // Mode is live until the first edge after reset, then frozen
  assign w_mode       = r_mode_vld ? r_mode : bus.MODE_I;
  assign w_wr_acc     = bus.STORE_I & r_perm;
  assign w_can_rd     = w_mode ? (r_count != '0)
                               : ((r_state == S_DONE) | (r_state == S_READ));
  assign w_rd_acc     = bus.LOAD_REQUEST_I & ~r_grant & w_can_rd & r_mode_vld;
  assign w_trg_arm    = w_mode | (r_state == S_FILL);
  assign w_wr_ptr_nxt = w_wr_acc ? r_wr_ptr + AW'(1) : r_wr_ptr;
  assign w_enter_done = ~w_mode & ((r_state == S_FILL) | (r_state == S_POST))
                      & (w_state_nxt == S_DONE);

  // Trace-mode capture/readout sequencing and post-trigger countdown
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!w_mode) begin
      case (r_state)
        S_FILL: if (w_wr_acc && bus.TRG_EVENT_I) begin
          w_cnt_nxt   = bus.TRG_DELAY_I;
          w_state_nxt = (bus.TRG_DELAY_I == '0) ? S_DONE : S_POST;
        end
        S_POST: if (w_wr_acc) begin
          w_cnt_nxt = r_cnt - AW'(1);
          if (r_cnt == AW'(1)) w_state_nxt = S_DONE;
        end
        S_DONE: if (w_rd_acc) w_state_nxt = S_READ;
        default: w_state_nxt = S_DONE;
      endcase
    end
  end

  // Occupancy: FIFO count in stream mode, saturating valid-word count in trace
  always_comb begin
    w_count_nxt = r_count;
    if (w_mode)
      w_count_nxt = r_count + {{AW{1'b0}}, w_wr_acc} - {{AW{1'b0}}, w_rd_acc};
    else if (w_wr_acc && (r_count != FULL_CNT))
      w_count_nxt = r_count + (AW+1)'(1);
  end

  // Permission is registered so the tracer sees it from a clean flop
  always_comb begin
    if (w_mode) w_perm_nxt = (w_count_nxt < FULL_CNT);
    else        w_perm_nxt = (w_state_nxt == S_FILL) | (w_state_nxt == S_POST);
  end

  // Storage array; contents deliberately survive reset
  always_ff @(posedge FPGA_CLK_I) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.DATA_I;
  end

  // Control state, pointers and registered outputs
  always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      r_state    <= S_FILL;
      r_mode     <= 1'b0;
      r_mode_vld <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cnt      <= '0;
      r_perm     <= 1'b0;
      r_grant    <= 1'b0;
      r_delayed  <= 1'b0;
      r_data     <= '0;
      r_trg_addr <= '0;
      r_evt_pos  <= '0;
    end else begin
      r_mode_vld <= 1'b1;
      if (!r_mode_vld) r_mode <= bus.MODE_I;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_count    <= w_count_nxt;
      r_perm     <= w_perm_nxt;
      r_grant    <= w_rd_acc;
      r_delayed  <= ~w_mode & ((r_state == S_DONE) | (r_state == S_READ));
      if (w_rd_acc) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end else if (w_enter_done) begin
        // Slot about to be overwritten next is the oldest one kept
        r_rd_ptr <= w_wr_ptr_nxt;
      end
      if (w_wr_acc && bus.TRG_EVENT_I && w_trg_arm) begin
        r_trg_addr <= r_wr_ptr;
        r_evt_pos  <= bus.EVENT_POS_I;
      end
    end
  end

  assign bus.STORE_PERM_O  = r_perm;
  assign bus.LOAD_GRANT_O  = r_grant;
  assign bus.TRG_DELAYED_O = r_delayed;
  assign bus.DATA_O        = r_data;
  assign bus.TRG_ADDR_O    = r_trg_addr;
  assign bus.EVENT_POS_O   = r_evt_pos;
  assign bus.FILL_O        = r_count;
endmodule

// File: tb/tb_trb_mem_ctrl.sv
// Directed bench for trb_mem_ctrl: trace capture/replay, zero post-trigger
// delay, reset during capture, and stream FIFO full/empty behaviour.
module tb_trb_mem_ctrl;
  localparam int W = 32;
  localparam int D = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trb_mem_ctrl_if #(.TRB_WIDTH(W), .TRB_DEPTH(D)) bus ();

  trb_mem_ctrl #(.TRB_WIDTH(W), .TRB_DEPTH(D)) dut (
    .FPGA_CLK_I (clk),
    .RST_NI     (rst_n),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_w;
  logic [W-1:0] last_w;
  int ngr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_perm"},    64'(bus.STORE_PERM_O),  0);
    chk({tag, "_grant"},   64'(bus.LOAD_GRANT_O),  0);
    chk({tag, "_delayed"}, 64'(bus.TRG_DELAYED_O), 0);
    chk({tag, "_data"},    64'(bus.DATA_O),        0);
    chk({tag, "_addr"},    64'(bus.TRG_ADDR_O),    0);
    chk({tag, "_pos"},     64'(bus.EVENT_POS_O),   0);
    chk({tag, "_fill"},    64'(bus.FILL_O),        0);
  endtask

  task automatic do_reset(input logic mode, input int dly);
    rst_n              = 1'b0;
    bus.STORE_I        = 1'b0;
    bus.DATA_I         = '0;
    bus.TRG_EVENT_I    = 1'b0;
    bus.EVENT_POS_I    = '0;
    bus.LOAD_REQUEST_I = 1'b0;
    bus.MODE_I         = mode;
    bus.TRG_DELAY_I    = 6'(dly);
    tick();
    tick();
    chk_rst("rst");
    rst_n = 1'b1;
    tick();
    chk("perm_after_release", 64'(bus.STORE_PERM_O), 1);
  endtask

  initial begin
    // ---------------- trace mode: capture with trigger at k=70 ----------
    do_reset(1'b0, 5);
    for (int k = 0; k < 100; k++) begin
      bus.STORE_I        = 1'b1;
      bus.DATA_I         = W'(k);
      bus.TRG_EVENT_I    = (k == 70);
      bus.EVENT_POS_I    = (k == 70) ? 5'd13 : 5'd0;
      bus.LOAD_REQUEST_I = (k < 20);
      tick();
      if (k < 20)  chk("no_grant_before_done", 64'(bus.LOAD_GRANT_O), 0);
      if (k == 10) chk("trace_fill_11", 64'(bus.FILL_O), 11);
      if (k == 70) begin
        chk("trg_addr", 64'(bus.TRG_ADDR_O), 6);
        chk("evt_pos",  64'(bus.EVENT_POS_O), 13);
        chk("perm_k70", 64'(bus.STORE_PERM_O), 1);
      end
      if (k == 74) begin
        chk("perm_k74",    64'(bus.STORE_PERM_O), 1);
        chk("delayed_k74", 64'(bus.TRG_DELAYED_O), 0);
      end
      if (k == 75) begin
        chk("perm_k75",    64'(bus.STORE_PERM_O), 0);
        chk("delayed_k75", 64'(bus.TRG_DELAYED_O), 0);
        chk("fill_sat",    64'(bus.FILL_O), 64);
      end
      if (k == 76) chk("delayed_k76", 64'(bus.TRG_DELAYED_O), 1);
      if (k == 99) begin
        chk("trg_addr_held", 64'(bus.TRG_ADDR_O), 6);
        chk("fill_k99",      64'(bus.FILL_O), 64);
      end
    end
    bus.STORE_I     = 1'b0;
    bus.TRG_EVENT_I = 1'b0;

    // ---------------- trace readout: 64 words oldest-first, then wrap ----
    for (int i = 0; i < 66; i++) sb.push_back(W'(12 + (i % 64)));
    bus.LOAD_REQUEST_I = 1'b1;
    ngr    = 0;
    last_w = bus.DATA_O;
    for (int cyc = 1; cyc <= 300 && ngr < 66; cyc++) begin
      tick();
      if (bus.LOAD_GRANT_O) begin
        ngr++;
        exp_w = sb.pop_front();
        chk("trace_data", 64'(bus.DATA_O), 64'(exp_w));
        chk("grant_spacing", 64'(cyc), 64'(2*ngr - 1));
        last_w = bus.DATA_O;
      end else begin
        chk("data_stable", 64'(bus.DATA_O), 64'(last_w));
      end
    end
    chk("trace_readout_done", 64'(sb.size()), 0);
    bus.LOAD_REQUEST_I = 1'b0;
    tick();
    chk("trace_no_extra_grant", 64'(bus.LOAD_GRANT_O), 0);
    sb.delete();

    // ---------------- reset in the middle of post-trigger capture -------
    do_reset(1'b0, 5);
    for (int k = 0; k < 3; k++) begin
      bus.STORE_I     = 1'b1;
      bus.DATA_I      = W'(32'h500 + k);
      bus.TRG_EVENT_I = (k == 1);
      bus.EVENT_POS_I = (k == 1) ? 5'd7 : 5'd0;
      tick();
    end
    chk("mid_trg_addr", 64'(bus.TRG_ADDR_O), 1);
    chk("mid_evt_pos",  64'(bus.EVENT_POS_O), 7);
    chk("mid_fill",     64'(bus.FILL_O), 3);
    bus.TRG_EVENT_I    = 1'b0;
    bus.STORE_I        = 1'b0;
    bus.LOAD_REQUEST_I = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_perm",    64'(bus.STORE_PERM_O), 1);
    chk("post_rst_grant",   64'(bus.LOAD_GRANT_O), 0);
    chk("post_rst_addr",    64'(bus.TRG_ADDR_O), 0);
    for (int k = 0; k < 10; k++) begin
      bus.STORE_I = 1'b1;
      bus.DATA_I  = W'(k);
      tick();
    end
    bus.STORE_I = 1'b0;
    chk("post_rst_perm_held", 64'(bus.STORE_PERM_O), 1);
    chk("post_rst_delayed",   64'(bus.TRG_DELAYED_O), 0);
    chk("post_rst_grant2",    64'(bus.LOAD_GRANT_O), 0);
    chk("post_rst_fill",      64'(bus.FILL_O), 10);
    bus.LOAD_REQUEST_I = 1'b0;

    // ---------------- zero post-trigger delay -----------------------------
    do_reset(1'b0, 0);
    bus.STORE_I     = 1'b1;
    bus.DATA_I      = 32'hAAAA;
    bus.TRG_EVENT_I = 1'b1;
    bus.EVENT_POS_I = 5'd3;
    tick();
    bus.STORE_I     = 1'b0;
    bus.TRG_EVENT_I = 1'b0;
    chk("d0_perm",    64'(bus.STORE_PERM_O), 0);
    chk("d0_fill",    64'(bus.FILL_O), 1);
    chk("d0_addr",    64'(bus.TRG_ADDR_O), 0);
    chk("d0_pos",     64'(bus.EVENT_POS_O), 3);
    chk("d0_delayed_early", 64'(bus.TRG_DELAYED_O), 0);
    tick();
    chk("d0_delayed", 64'(bus.TRG_DELAYED_O), 1);

    // ---------------- stream mode: empty FIFO, request held --------------
    do_reset(1'b1, 0);
    bus.LOAD_REQUEST_I = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("empty_no_grant", 64'(bus.LOAD_GRANT_O), 0);
    end
    chk("stream_delayed", 64'(bus.TRG_DELAYED_O), 0);
    bus.STORE_I = 1'b1;
    bus.DATA_I  = 32'h1234;
    sb.push_back(32'h1234);
    tick();
    bus.STORE_I = 1'b0;
    chk("first_store_no_grant_yet", 64'(bus.LOAD_GRANT_O), 0);
    tick();
    chk("first_store_grant", 64'(bus.LOAD_GRANT_O), 1);
    exp_w = sb.pop_front();
    chk("first_store_data", 64'(bus.DATA_O), 64'(exp_w));
    bus.LOAD_REQUEST_I = 1'b0;
    tick();
    chk("stream_empty_fill", 64'(bus.FILL_O), 0);

    // ---------------- stream mode: fill to full --------------------------
    for (int i = 0; i < 64; i++) begin
      bus.STORE_I     = 1'b1;
      bus.DATA_I      = W'(32'h100 + i);
      bus.TRG_EVENT_I = (i == 9);
      bus.EVENT_POS_I = (i == 9) ? 5'd21 : 5'd0;
      sb.push_back(W'(32'h100 + i));
      tick();
      if (i == 31) chk("stream_fill_32", 64'(bus.FILL_O), 32);
    end
    bus.TRG_EVENT_I = 1'b0;
    chk("stream_full_fill", 64'(bus.FILL_O), 64);
    chk("stream_full_perm", 64'(bus.STORE_PERM_O), 0);
    chk("stream_trg_addr",  64'(bus.TRG_ADDR_O), 10);
    chk("stream_trg_pos",   64'(bus.EVENT_POS_O), 21);
    bus.DATA_I = 32'hDEAD;
    tick();
    chk("full_store_dropped", 64'(bus.FILL_O), 64);
    bus.STORE_I = 1'b0;

    // one load frees a slot, then a store and a load in the same cycle
    bus.LOAD_REQUEST_I = 1'b1;
    tick();
    bus.LOAD_REQUEST_I = 1'b0;
    chk("load1_grant", 64'(bus.LOAD_GRANT_O), 1);
    exp_w = sb.pop_front();
    chk("load1_data", 64'(bus.DATA_O), 64'(exp_w));
    chk("load1_fill", 64'(bus.FILL_O), 63);
    tick();
    chk("load1_perm", 64'(bus.STORE_PERM_O), 1);
    bus.LOAD_REQUEST_I = 1'b1;
    bus.STORE_I        = 1'b1;
    bus.DATA_I         = 32'h200;
    sb.push_back(32'h200);
    tick();
    bus.LOAD_REQUEST_I = 1'b0;
    chk("simul_grant", 64'(bus.LOAD_GRANT_O), 1);
    exp_w = sb.pop_front();
    chk("simul_data", 64'(bus.DATA_O), 64'(exp_w));
    chk("simul_fill_net0", 64'(bus.FILL_O), 63);
    bus.DATA_I = 32'h201;
    sb.push_back(32'h201);
    tick();
    bus.STORE_I = 1'b0;
    chk("refill_fill", 64'(bus.FILL_O), 64);
    chk("refill_perm", 64'(bus.STORE_PERM_O), 0);

    // ---------------- stream mode: drain in FIFO order -------------------
    bus.LOAD_REQUEST_I = 1'b1;
    last_w = bus.DATA_O;
    for (int cyc = 0; cyc < 400 && sb.size() > 0; cyc++) begin
      tick();
      if (bus.LOAD_GRANT_O) begin
        exp_w = sb.pop_front();
        chk("fifo_data", 64'(bus.DATA_O), 64'(exp_w));
        last_w = bus.DATA_O;
      end else begin
        chk("fifo_data_stable", 64'(bus.DATA_O), 64'(last_w));
      end
    end
    chk("drain_done", 64'(sb.size()), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drained_no_grant", 64'(bus.LOAD_GRANT_O), 0);
    end
    chk("drained_fill", 64'(bus.FILL_O), 0);
    chk("drained_perm", 64'(bus.STORE_PERM_O), 1);
    bus.LOAD_REQUEST_I = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
